// File: rtl/viterbi_ber_ctrl.sv
// Purpose: sequences one BER run through encoder -> channel -> Viterbi decoder, counting decoded errors and injected flips.
// Latency: done_o pulses 1+FRAME_LEN+DEC_LAT+ENC_LAT+1 cycles after start_i is sampled; decoder compare is DEC_LAT behind enc_data_o.
// Backpressure: none; the chain is free-running and start_i is ignored while a run is in progress.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   start_i                  launch a run (sampled in IDLE only)
//   inj_en_i, burst_i, seed_i  run configuration, latched in LOAD
//   enc_data_o, enc_en_o     payload bit and enable towards the encoder
//   err_mask_o               2-bit XOR mask for the channel symbol
//   dec_data_i               decoder output bit
//   busy_o, done_o           run in progress / one-cycle completion pulse
//   bit_err_cnt_o, inj_cnt_o saturating statistics counters
module viterbi_ber_ctrl #(
    parameter int FRAME_LEN = 256,
    parameter int DEC_LAT   = 40,
    parameter int ENC_LAT   = 1,
    parameter int ERR_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             inj_en_i,
    input  logic             burst_i,
    input  logic [15:0]      seed_i,
    output logic             enc_data_o,
    output logic             enc_en_o,
    output logic [1:0]       err_mask_o,
    input  logic             dec_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] bit_err_cnt_o,
    output logic [CNT_W-1:0] inj_cnt_o
);

    localparam int          FLUSH_LEN = DEC_LAT + ENC_LAT;
    localparam int          RC_W      = $clog2((FRAME_LEN > FLUSH_LEN) ? FRAME_LEN : FLUSH_LEN) + 1;
    localparam int          MW        = 2 * ENC_LAT;
    localparam logic [15:0] PAY_INIT  = 16'hACE1;
    localparam logic [31:0] ERR_POLY  = 32'h80200003;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state;
    logic [RC_W-1:0]   run_cnt;
    logic [15:0]       pay_lfsr;
    logic [31:0]       err_lfsr;
    logic              inj_en_q;
    logic              burst_q;
    logic [MW-1:0]     mask_sr;     // ENC_LAT stages of 2-bit masks, oldest in the top pair
    logic [DEC_LAT-1:0] ref_dat;
    logic [DEC_LAT-1:0] ref_vld;
    logic [1:0]        mask_now;
    logic [15:0]       pay_seed;
    logic              err_hit;

    // Fibonacci, taps 16,14,13,11 -> bits 0,2,3,5, shifting toward bit 0.
    function automatic logic [15:0] pay_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Right-shifting Galois form of polynomial 0x80200003.
    function automatic logic [31:0] err_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ ERR_POLY) : (l >> 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // An all-zero seed would lock the LFSR, so it falls back to the reset pattern.
    assign pay_seed   = (seed_i == 16'h0) ? PAY_INIT : seed_i;
    assign err_mask_o = mask_sr[MW-1 -: 2];
    assign err_hit    = ref_vld[DEC_LAT-1] && (dec_data_i != ref_dat[DEC_LAT-1]);

    always_comb begin
        mask_now = 2'b00;
        if (state == S_RUN && inj_en_q && (&err_lfsr[ERR_W-1:0])) begin
            mask_now = burst_q ? 2'b11 : (err_lfsr[28] ? 2'b10 : 2'b01);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            run_cnt       <= '0;
            pay_lfsr      <= PAY_INIT;
            err_lfsr      <= 32'h1;
            inj_en_q      <= 1'b0;
            burst_q       <= 1'b0;
            mask_sr       <= '0;
            ref_dat       <= '0;
            ref_vld       <= '0;
            enc_data_o    <= 1'b0;
            enc_en_o      <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            bit_err_cnt_o <= '0;
            inj_cnt_o     <= '0;
        end else begin
            done_o  <= 1'b0;
            // Injection decisions ride ENC_LAT stages so the mask meets its encoder symbol.
            mask_sr <= MW'({mask_sr, mask_now});
            ref_dat <= DEC_LAT'({ref_dat, enc_data_o});
            ref_vld <= DEC_LAT'({ref_vld, enc_en_o});

            // LOAD clear wins over any increment in the same cycle.
            if (state == S_LOAD) begin
                bit_err_cnt_o <= '0;
                inj_cnt_o     <= '0;
            end else begin
                bit_err_cnt_o <= sat_add(bit_err_cnt_o, {1'b0, err_hit});
                inj_cnt_o     <= sat_add(inj_cnt_o, {1'b0, err_mask_o[1]} + {1'b0, err_mask_o[0]});
            end

            if (state == S_RUN) begin
                err_lfsr <= err_step(err_lfsr);
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state  <= S_LOAD;
                        busy_o <= 1'b1;
                    end
                end
                S_LOAD: begin
                    inj_en_q   <= inj_en_i;
                    burst_q    <= burst_i;
                    // First payload bit leaves on the edge entering RUN.
                    enc_data_o <= pay_seed[0];
                    enc_en_o   <= 1'b1;
                    pay_lfsr   <= pay_step(pay_seed);
                    run_cnt    <= '0;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    if (run_cnt == RC_W'(FRAME_LEN - 1)) begin
                        enc_en_o   <= 1'b0;
                        enc_data_o <= 1'b0;
                        run_cnt    <= '0;
                        state      <= S_FLUSH;
                    end else begin
                        enc_data_o <= pay_lfsr[0];
                        pay_lfsr   <= pay_step(pay_lfsr);
                        run_cnt    <= run_cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (run_cnt == RC_W'(FLUSH_LEN - 1)) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_ber_ctrl.sv
// Purpose: scoreboard bench for viterbi_ber_ctrl: payload, mask schedule, counters and run timing.
// Latency: expectations are queued as each run is launched and popped as encoder cycles appear.
// Backpressure: none; the decoder is modelled as an ideal DEC_LAT delay with optional bit inversions.
module tb_viterbi_ber_ctrl;

    localparam int FL    = 256;
    localparam int DL    = 40;
    localparam int EL    = 1;
    localparam int ERR_W = 3;
    localparam int CW    = 16;
    localparam int FL2   = 32;
    localparam int DL2   = 5;
    localparam int CW2   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_i, inj_en_i, burst_i, dec_data_i;
    logic [15:0]   seed_i;
    logic          enc_data_o, enc_en_o, busy_o, done_o;
    logic [1:0]    err_mask_o;
    logic [CW-1:0] bit_err_cnt_o, inj_cnt_o;

    logic           start_s, inj_s, burst_s, dec_s;
    logic [15:0]    seed_s;
    logic           enc_data_s, enc_en_s, busy_s, done_s;
    logic [1:0]     mask_s;
    logic [CW2-1:0] bit_err_s, inj_cnt_s;

    viterbi_ber_ctrl #(.FRAME_LEN(FL), .DEC_LAT(DL), .ENC_LAT(EL), .ERR_W(ERR_W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .inj_en_i(inj_en_i), .burst_i(burst_i),
        .seed_i(seed_i), .enc_data_o(enc_data_o), .enc_en_o(enc_en_o), .err_mask_o(err_mask_o),
        .dec_data_i(dec_data_i), .busy_o(busy_o), .done_o(done_o),
        .bit_err_cnt_o(bit_err_cnt_o), .inj_cnt_o(inj_cnt_o)
    );

    viterbi_ber_ctrl #(.FRAME_LEN(FL2), .DEC_LAT(DL2), .ENC_LAT(1), .ERR_W(3), .CNT_W(CW2)) dut_sat (
        .clk(clk), .rst(rst), .start_i(start_s), .inj_en_i(inj_s), .burst_i(burst_s),
        .seed_i(seed_s), .enc_data_o(enc_data_s), .enc_en_o(enc_en_s), .err_mask_o(mask_s),
        .dec_data_i(dec_s), .busy_o(busy_s), .done_o(done_s),
        .bit_err_cnt_o(bit_err_s), .inj_cnt_o(inj_cnt_s)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          pay_q[$];
    logic [1:0]  mask_q[$];
    logic [31:0] m_err = 32'h1;
    bit          hist[DL];

    int          r_done_cyc, r_en_cnt, r_nz, r_exp_nz, r_mask_sum, r_window_bad;
    logic [3:0]  r_first4;

    function automatic logic [15:0] pay_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        start_i = 1'b0; inj_en_i = 1'b0; burst_i = 1'b0; seed_i = 16'h0; dec_data_i = 1'b0;
        start_s = 1'b0; inj_s = 1'b0; burst_s = 1'b0; seed_s = 16'h0; dec_s = 1'b0;
        pay_q.delete();
        mask_q.delete();
        m_err = 32'h1;
        for (int i = 0; i < DL; i++) hist[i] = 1'b0;
    endtask

    // Launches one run on the main DUT and scoreboards it until done_o (or abort/timeout).
    task automatic run_frame(input logic [15:0] seed, input bit inj, input bit burst,
                             input int inv_a, input int inv_b, input bit late_force, input int abort_at);
        logic [15:0] s;
        logic [1:0]  m, exp_m;
        bit          exp_b, prev_en, force_on, seen_done, aborted;
        int          cyc, n_en, fl;
        s = (seed == 16'h0) ? 16'hACE1 : seed;
        for (int i = 0; i < FL; i++) begin
            pay_q.push_back(s[0]);
            s = pay_next(s);
        end
        r_done_cyc = -1; r_nz = 0; r_exp_nz = 0; r_mask_sum = 0; r_window_bad = 0; r_first4 = 4'h0;
        prev_en = 1'b0; force_on = 1'b0; seen_done = 1'b0; aborted = 1'b0;
        n_en = 0; fl = 0; cyc = 0;
        @(negedge clk);
        start_i = 1'b1; seed_i = seed; inj_en_i = inj; burst_i = burst;
        while (!seen_done && !aborted && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start_i = 1'b0;
            if (cyc == 2) begin
                seed_i = 16'($urandom); inj_en_i = ~inj; burst_i = ~burst;
            end
            dec_data_i = hist[DL-1] ^ force_on;
            for (int i = DL - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = enc_data_o ^ (enc_en_o && (n_en == inv_a || n_en == inv_b));
            if (prev_en) begin
                n_cmp++;
                if (mask_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL mask_queue: got mask %b with no expectation queued", err_mask_o);
                end else begin
                    exp_m = mask_q.pop_front();
                    if (err_mask_o !== exp_m) begin
                        n_bad++;
                        $display("FAIL err_mask cyc %0d: got %b want %b", cyc, err_mask_o, exp_m);
                    end
                    if (err_mask_o != 2'b00) r_nz++;
                end
            end else if (err_mask_o !== 2'b00) begin
                r_window_bad++;
            end
            if (enc_en_o) begin
                n_cmp++;
                if (pay_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL enc_extra: got enc_en_o beyond %0d bits", FL);
                end else begin
                    exp_b = pay_q.pop_front();
                    if (enc_data_o !== exp_b) begin
                        n_bad++;
                        $display("FAIL enc_data bit %0d: got %b want %b", n_en, enc_data_o, exp_b);
                    end
                end
                if (n_en < 4) r_first4[n_en] = enc_data_o;
                m = 2'b00;
                if (inj && (&m_err[ERR_W-1:0])) m = burst ? 2'b11 : (m_err[28] ? 2'b10 : 2'b01);
                mask_q.push_back(m);
                r_mask_sum += int'(m[0]) + int'(m[1]);
                if (m != 2'b00) r_exp_nz++;
                m_err = m_err[0] ? ((m_err >> 1) ^ 32'h80200003) : (m_err >> 1);
                n_en++;
            end else if (n_en == FL) begin
                fl++;
                // Inverting decoder output from here on lands past the last valid compare.
                if (late_force && fl == DL) force_on = 1'b1;
            end
            prev_en = enc_en_o;
            if (done_o) begin
                seen_done = 1'b1;
                r_done_cyc = cyc;
            end
            if (abort_at > 0 && n_en == abort_at) aborted = 1'b1;
        end
        r_en_cnt = n_en;
        dec_data_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (enc_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_enc_en: got %b want 0", enc_en_o); end
        n_cmp++; if (enc_data_o !== 1'b0) begin n_bad++; $display("FAIL reset_enc_data: got %b want 0", enc_data_o); end
        n_cmp++; if (err_mask_o !== 2'b00) begin n_bad++; $display("FAIL reset_mask: got %b want 00", err_mask_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_cmp++; if (bit_err_cnt_o !== '0) begin n_bad++; $display("FAIL reset_bit_err: got %0d want 0", bit_err_cnt_o); end
        n_cmp++; if (inj_cnt_o !== '0) begin n_bad++; $display("FAIL reset_inj: got %0d want 0", inj_cnt_o); end
        n_cmp++; if (bit_err_s !== '0) begin n_bad++; $display("FAIL reset_sat_cnt: got %0d want 0", bit_err_s); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        run_frame(16'h1234, 1'b1, 1'b0, -1, -1, 1'b0, 100);
        rst = 1'b1;
        #1;
        n_cmp++; if (enc_en_o !== 1'b0 || enc_data_o !== 1'b0 || err_mask_o !== 2'b00 || busy_o !== 1'b0)
            begin n_bad++; $display("FAIL midrun_outputs: got en %b dat %b mask %b busy %b want all 0", enc_en_o, enc_data_o, err_mask_o, busy_o); end
        n_cmp++; if (bit_err_cnt_o !== '0 || inj_cnt_o !== '0)
            begin n_bad++; $display("FAIL midrun_counters: got %0d/%0d want 0/0", bit_err_cnt_o, inj_cnt_o); end
        apply_reset();
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done) begin n_bad++; $display("FAIL midrun_no_done: got done_o after abort want none"); end
        run_frame(16'h1234, 1'b1, 1'b0, -1, -1, 1'b0, 0);
        n_cmp++; if (r_done_cyc != 1 + FL + DL + EL + 1) begin n_bad++; $display("FAIL fresh_done_cyc: got %0d want %0d", r_done_cyc, 1 + FL + DL + EL + 1); end
        n_cmp++; if (inj_cnt_o !== CW'(r_mask_sum)) begin n_bad++; $display("FAIL fresh_inj: got %0d want %0d", inj_cnt_o, r_mask_sum); end
    endtask

    task automatic test_clean_run();
        run_frame(16'h0001, 1'b0, 1'b0, -1, -1, 1'b0, 0);
        n_cmp++; if (r_en_cnt != FL) begin n_bad++; $display("FAIL clean_en_cycles: got %0d want %0d", r_en_cnt, FL); end
        n_cmp++; if (r_nz != 0 || r_window_bad != 0) begin n_bad++; $display("FAIL clean_mask: got %0d in-window %0d out-window want 0/0", r_nz, r_window_bad); end
        n_cmp++; if (r_done_cyc != 1 + FL + DL + EL + 1) begin n_bad++; $display("FAIL clean_done_cyc: got %0d want %0d", r_done_cyc, 1 + FL + DL + EL + 1); end
        @(negedge clk);
        n_cmp++; if (bit_err_cnt_o !== '0) begin n_bad++; $display("FAIL clean_bit_err: got %0d want 0", bit_err_cnt_o); end
        n_cmp++; if (inj_cnt_o !== '0) begin n_bad++; $display("FAIL clean_inj: got %0d want 0", inj_cnt_o); end
    endtask

    task automatic test_seed_zero();
        run_frame(16'h0000, 1'b0, 1'b0, -1, -1, 1'b0, 0);
        n_cmp++; if (r_first4 !== 4'b0001) begin n_bad++; $display("FAIL seed0_first4: got %b want 0001 (bit0 first)", r_first4); end
        n_cmp++; if (r_done_cyc != 1 + FL + DL + EL + 1) begin n_bad++; $display("FAIL seed0_done_cyc: got %0d want %0d", r_done_cyc, 1 + FL + DL + EL + 1); end
    endtask

    task automatic test_burst_inject();
        run_frame(16'hBEEF, 1'b1, 1'b1, -1, -1, 1'b0, 0);
        n_cmp++; if (r_nz != r_exp_nz) begin n_bad++; $display("FAIL burst_mask_count: got %0d want %0d", r_nz, r_exp_nz); end
        n_cmp++; if (r_window_bad != 0) begin n_bad++; $display("FAIL burst_window: got %0d masks outside window want 0", r_window_bad); end
        n_cmp++; if (inj_cnt_o !== CW'(2 * r_exp_nz)) begin n_bad++; $display("FAIL burst_inj: got %0d want %0d", inj_cnt_o, 2 * r_exp_nz); end
        n_cmp++; if (inj_cnt_o[0] !== 1'b0) begin n_bad++; $display("FAIL burst_inj_even: got %0d want even", inj_cnt_o); end
        n_cmp++; if (bit_err_cnt_o !== '0) begin n_bad++; $display("FAIL burst_bit_err: got %0d want 0", bit_err_cnt_o); end
    endtask

    task automatic test_decode_errors();
        run_frame(16'h5A5A, 1'b0, 1'b0, 10, 200, 1'b1, 0);
        n_cmp++; if (bit_err_cnt_o !== CW'(2)) begin n_bad++; $display("FAIL dec_err_count: got %0d want 2", bit_err_cnt_o); end
        repeat (5) @(negedge clk);
        n_cmp++; if (bit_err_cnt_o !== CW'(2)) begin n_bad++; $display("FAIL dec_err_hold: got %0d want 2", bit_err_cnt_o); end
    endtask

    task automatic test_back_to_back();
        int first_sum;
        run_frame(16'h00A5, 1'b1, 1'b0, -1, -1, 1'b0, 0);
        first_sum = r_mask_sum;
        n_cmp++; if (inj_cnt_o !== CW'(first_sum)) begin n_bad++; $display("FAIL b2b_first_inj: got %0d want %0d", inj_cnt_o, first_sum); end
        run_frame(16'h7001, 1'b1, 1'b0, 3, -1, 1'b0, 0);
        n_cmp++; if (inj_cnt_o !== CW'(r_mask_sum)) begin n_bad++; $display("FAIL b2b_second_inj: got %0d want %0d", inj_cnt_o, r_mask_sum); end
        n_cmp++; if (bit_err_cnt_o !== CW'(1)) begin n_bad++; $display("FAIL b2b_bit_err: got %0d want 1", bit_err_cnt_o); end
    endtask

    task automatic test_saturation();
        bit h2[DL2];
        int dones, dcyc, en_cnt, mask_bad;
        for (int i = 0; i < DL2; i++) h2[i] = 1'b0;
        dones = 0; dcyc = -1; en_cnt = 0; mask_bad = 0;
        @(negedge clk);
        start_s = 1'b1; seed_s = 16'h00FF; inj_s = 1'b0; burst_s = 1'b0;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            @(negedge clk);
            start_s = busy_s && (cyc % 3 == 0);
            dec_s = ~h2[DL2-1];
            for (int i = DL2 - 1; i > 0; i--) h2[i] = h2[i-1];
            h2[0] = enc_data_s;
            if (enc_en_s) en_cnt++;
            if (mask_s !== 2'b00) mask_bad++;
            if (done_s) begin
                dones++;
                if (dcyc < 0) dcyc = cyc;
            end
        end
        start_s = 1'b0;
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL sat_done_pulses: got %0d want 1", dones); end
        n_cmp++; if (dcyc != 1 + FL2 + DL2 + 1 + 1) begin n_bad++; $display("FAIL sat_done_cyc: got %0d want %0d", dcyc, 1 + FL2 + DL2 + 2); end
        n_cmp++; if (en_cnt != FL2) begin n_bad++; $display("FAIL sat_en_cycles: got %0d want %0d", en_cnt, FL2); end
        n_cmp++; if (bit_err_s !== 4'd15) begin n_bad++; $display("FAIL sat_bit_err: got %0d want 15", bit_err_s); end
        n_cmp++; if (inj_cnt_s !== 4'd0 || mask_bad != 0) begin n_bad++; $display("FAIL sat_inj: got %0d cnt %0d masks want 0/0", inj_cnt_s, mask_bad); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_clean_run();
        test_seed_zero();
        test_burst_inject();
        test_decode_errors();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_ctrl.md
Name: viterbi_ber_ctrl

Overview:
- Sequences one bit-error-rate test run through the convolutional encoder -> channel -> Viterbi decoder chain.
- Generates the pseudo-random payload and encoder enable for a frame.
- Schedules channel error injection as a 2-bit symbol mask.
- Aligns a reference copy of the payload with the decoder output, then counts decoded bit errors and injected channel bit flips.

Parameters:
FRAME_LEN, 256, payload bits per run (>=2)
DEC_LAT, 40, cycles from enc_data_o/enc_en_o to matching dec_data_i (>=1)
ENC_LAT, 1, cycles from enc_en_o to the encoder symbol that err_mask_o must align with
ERR_W, 3, injection when low ERR_W bits of error LFSR are all ones (rate ~2^-ERR_W)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  launch a run; sampled only in IDLE
inj_en_i  in  1  enable error injection; sampled in LOAD, held for the run
burst_i  in  1  1 = flip both symbol bits, 0 = flip one bit; sampled in LOAD
seed_i  in  16  payload LFSR seed; sampled in LOAD
enc_data_o  out  1  payload bit to encoder
enc_en_o  out  1  encoder enable
err_mask_o  out  2  XOR mask for the channel symbol
dec_data_i  in  1  decoder output bit
busy_o  out  1  high in LOAD/RUN/FLUSH
done_o  out  1  one-cycle pulse on run completion
bit_err_cnt_o  out  CNT_W  decoded bits mismatching the reference
inj_cnt_o  out  CNT_W  channel bits flipped

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All outputs = 0 and both counters = 0.
  - Payload LFSR = 16'hACE1; error LFSR = 32'h1; delay lines cleared.
  - Reset asserted mid-run aborts the run with no done_o.
- FSM states: IDLE, LOAD, RUN, FLUSH, DONE.
  - IDLE -> LOAD when start_i=1. start_i in any other state is ignored.
  - LOAD (1 cycle):
    - Latch inj_en_i and burst_i.
    - Load the payload LFSR with seed_i; seed 0 loads 16'hACE1.
    - Clear both counters and the run counter.
  - RUN (exactly FRAME_LEN cycles):
    - enc_en_o=1; enc_data_o = payload LFSR bit 0.
    - Payload LFSR steps once per cycle: Fibonacci, taps 16,14,13,11, shift toward bit 0, feedback into bit 15.
  - FLUSH (exactly DEC_LAT+ENC_LAT cycles):
    - enc_en_o=0, enc_data_o=0.
    - No new injections are scheduled; the comparison pipeline drains.
  - DONE (1 cycle): done_o=1, then IDLE.
- Outputs are registered. enc_en_o and enc_data_o change on the edge entering or leaving RUN.
- Injection decision:
  - Made each RUN cycle from the error LFSR: 32-bit Galois, polynomial 0x80200003, steps every cycle in RUN.
  - Inject when inj_en_i (latched) and lfsr[ERR_W-1:0] are all ones.
  - Mask = burst ? 2'b11 : (lfsr[28] ? 2'b10 : 2'b01).
  - The mask is delayed ENC_LAT cycles, so err_mask_o is nonzero in the cycle the corresponding encoder symbol is valid. Otherwise err_mask_o = 2'b00.
  - inj_cnt_o increments by popcount(mask) when the mask is issued on err_mask_o.
- Reference alignment:
  - enc_data_o and a valid bit (= enc_en_o) pass through a DEC_LAT-deep shift register.
  - When the delayed valid is 1 and dec_data_i differs from the delayed data, bit_err_cnt_o increments by 1.
  - Exactly FRAME_LEN comparisons per run.
- Counters saturate at 2^CNT_W-1 (no wrap). They hold their final value after DONE until the next LOAD.
- Simultaneous events: an increment and the LOAD clear in the same cycle resolve to 0. This cannot occur in legal operation; the rule is stated for completeness.

Test Plan:
- Reset mid-RUN (cycle 100 of 256) -> all outputs 0 next cycle. A following start_i behaves as a fresh run with identical enc_data_o sequence for the same seed.
- seed_i=16'h0001, inj_en_i=0, decoder modeled as ideal DEC_LAT=40 delay -> enc_en_o high exactly 256 cycles, err_mask_o always 0. done_o at cycle 1+256+41+1 after start; bit_err_cnt_o=0, inj_cnt_o=0.
- seed_i=0 -> payload identical to seed 16'hACE1; first 4 enc_data_o bits = 1,0,0,0 (LSB-first of 0xACE1).
- inj_en_i=1, burst_i=1, ERR_W=3, ideal-delay decoder with channel flips routed back -> inj_cnt_o even and equal to 2 x the count of nonzero err_mask_o cycles. No mask occurs outside the ENC_LAT-shifted RUN window.
- Model decoder inverting output bits 10 and 200 -> bit_err_cnt_o=2. Forcing a mismatch during FLUSH beyond the valid window -> count unchanged.
- CNT_W=4, decoder always inverted -> bit_err_cnt_o saturates at 15. start_i pulses during RUN and FLUSH are ignored; one done_o per run.
